// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stalls, branch flushes and mult/div EX occupancy (combinational outputs, 1-cycle md_done).
// Optional HAZARD_PERF_EN macro adds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       ex_md_start,
  input  logic       ex_md_is_div,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_clr,
  output logic       idex_en,
  output logic       idex_clr,
  output logic       exmem_en,
  output logic       exmem_clr,
  output logic       memwb_en,
  output logic       memwb_clr,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, MD_RUN = 1'b1} state_t;

  // Counter holds the number of stall cycles still to come after the current one.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic rs_hit, rt_hit, load_use, md_stall;

  assign rs_hit   = id_uses_rs && (id_rs == ex_rt);
  assign rt_hit   = id_uses_rt && (id_rt == ex_rt);
  assign load_use = ex_memread && (ex_rt != 5'd0) && (rs_hit || rt_hit);
  assign md_stall = ((state_q == IDLE) && ex_md_start) ||
                    ((state_q == MD_RUN) && (cnt_q != '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_md_start) begin
          cnt_d   = ex_md_is_div ? DIV_LOAD : MULT_LOAD;
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        // Opcode inputs are ignored here: the same instruction is held in EX.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    exmem_en  = 1'b1;
    exmem_clr = 1'b0;
    memwb_en  = 1'b1;
    memwb_clr = 1'b0;
    md_busy   = 1'b0;
    if (!rst) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      ifid_clr  = 1'b1;
      idex_en   = 1'b0;
      idex_clr  = 1'b1;
      exmem_en  = 1'b0;
      exmem_clr = 1'b1;
      memwb_en  = 1'b0;
      memwb_clr = 1'b1;
    end else if (md_stall) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_clr = 1'b1;
      md_busy   = 1'b1;
    end else if (ex_branch_taken) begin
      // Squashing ID also discards any load-use seen this cycle.
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  assign md_done = done_q;

`ifdef HAZARD_PERF_EN
  logic flush_apply;
  assign flush_apply = !md_stall && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_en && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_apply && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that drives the enable and clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and taken-branch flushes.
- Sequences multi-cycle multiply/divide occupancy of EX with a small state machine and down-counter.
- Sits beside the datapath in the CPU top; its outputs connect directly to the stage registers' en/rst pins.

Parameters:
- MULT_CYCLES, 4, total stall cycles charged to a multiply (>=1).
- DIV_CYCLES, 32, total stall cycles charged to a divide (>=1).
- CNT_W, 6, down-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- ex_md_start  in  1  instruction in EX is mult/multu/div/divu.
- ex_md_is_div  in  1  qualifies ex_md_start: 1 = divide.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID enable.
- ifid_clr  out  1  IF/ID clear (to register rst).
- idex_en  out  1  ID/EX enable.
- idex_clr  out  1  ID/EX clear.
- exmem_en  out  1  EX/MEM enable.
- exmem_clr  out  1  EX/MEM clear.
- memwb_en  out  1  MEM/WB enable.
- memwb_clr  out  1  MEM/WB clear.
- md_busy  out  1  multi-cycle op stalling EX.
- md_done  out  1  one-cycle pulse: HI/LO result valid this cycle.

Behaviour:
- Registered state: fsm (IDLE, MD_RUN), cnt[CNT_W-1:0], md_done.
- All other outputs are combinational from state and inputs.
- Reset (rst=0 at clk edge): fsm<=IDLE, cnt<=0, md_done<=0.
- While rst=0, outputs are forced: every *_en=0, every *_clr=1, md_busy=0.
- Default (no hazard): all en=1, all clr=0.
- load_use = ex_memread & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- md_stall = (fsm==IDLE & ex_md_start) | (fsm==MD_RUN & cnt!=0).
- Priority, highest first: reset > md_stall > ex_branch_taken > load_use.
- md_stall response:
  - pc_en=0, ifid_en=0, idex_en=0: PC, ID and EX frozen.
  - exmem_clr=1: bubble into MEM.
  - memwb_en=1: older instructions drain.
  - md_busy=1.
- ex_branch_taken response:
  - pc_en=1 (target loads).
  - ifid_clr=1, idex_clr=1: both wrong-path instructions squashed.
  - exmem/memwb advance normally.
  - A load_use in the same cycle is ignored, because its ID instruction is squashed.
- load_use response:
  - pc_en=0, ifid_en=0.
  - idex_clr=1: one bubble.
  - EX/MEM/WB advance.
  - Exactly one stall cycle, because the load leaves EX on that edge.
- FSM transitions:
  - IDLE & ex_md_start: cnt <= (ex_md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1, then go to MD_RUN.
  - MD_RUN & cnt!=0: cnt <= cnt-1. ex_md_start/ex_md_is_div are ignored (same instruction held).
  - MD_RUN & cnt==0: release cycle. md_stall=0, normal advance, md_done <= 1 at the edge, then go to IDLE.
  - md_done is high for exactly one cycle, the first cycle back in IDLE.
- Timing: a mult/div stalls PC exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) and occupies EX N+1 cycles.
- Back-to-back mult/div: the next op enters EX on the release edge and is seen in IDLE, restarting the sequence. No lost cycles.
- Reset mid-operation: the FSM returns to IDLE with no md_done pulse.
- Register $0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds two outputs:
  - perf_stall_cnt[31:0]: increments each cycle pc_en=0 while rst=1.
  - perf_flush_cnt[31:0]: increments each cycle a taken-branch flush is applied.
- Both counters saturate at 32'hFFFFFFFF and clear to 0 on reset.
- When not defined, the ports, counters and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 two cycles with ex_md_start=1 -> all en=0, all clr=1, md_busy=0; after release, default en=1/clr=0, md_done=0.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> exactly one cycle of pc_en=0, ifid_en=0, idex_clr=1. Repeat with ex_rt=0 -> no stall.
- Branch flush: ex_branch_taken=1 together with a matching load_use -> pc_en=1, ifid_clr=1, idex_clr=1, no stall.
- Multiply, MULT_CYCLES=4: ex_md_start=1, ex_md_is_div=0 -> md_busy=1 and pc_en=0 for 4 consecutive cycles; release cycle pc_en=1; md_done=1 the following cycle only.
- Divide then multiply back-to-back, DIV_CYCLES=32 -> 32 stall cycles, release, then 4 stall cycles immediately. Assert rst=0 at stall cycle 10 of the divide -> IDLE, no md_done pulse.
- HAZARD_PERF_EN: 3 load-use stalls plus 2 branch flushes -> perf_stall_cnt=3, perf_flush_cnt=2. Preload at 32'hFFFFFFFF -> holds (saturates).
